// File: rtl/alu_cmd_driver_if.sv
// Request/response handshake bundle between a host and the ALU command driver.
// master = host side, slave = driver side.
interface alu_cmd_driver_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic        req_use_acc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_divz;

    modport master (
        output req_valid, req_op, req_a, req_b, req_use_acc, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_divz
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_use_acc, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_divz
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// Initiator for a combinational 8-bit ALU: drives operands for SETTLE_CYCLES with oe high,
// captures the 16-bit result and returns it with status flags; keeps a chaining accumulator.
module alu_cmd_driver #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [7:0]  ACC_INIT      = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_cmd_driver_if.slave    bus,
    input  logic               acc_clr,
    output logic [7:0]         alu_a,
    output logic [7:0]         alu_b,
    output logic [3:0]         alu_cmd,
    output logic               alu_oe,
    input  logic [15:0]        alu_d,
    output logic [7:0]         acc
);

    localparam logic [3:0] OP_DIV   = 4'b0101;
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [3:0]  r_cnt;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [3:0]  r_cmd;
    logic [7:0]  r_acc;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_data;
    logic        r_rsp_zero;
    logic        r_rsp_divz;

    logic        w_req_ready;
    logic        w_oe;
    logic        w_accept;
    logic        w_last;
    logic        w_rsp_done;
    logic [7:0]  w_acc_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // alu_oe is decoded from the asynchronously reset state, so it drops the moment rst_n falls.
    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_oe         = 1'b0;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        w_rsp_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                w_accept    = bus.req_valid;
                if (bus.req_valid) begin
                    w_state_next = S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_oe   = 1'b1;
                w_last = (r_cnt == 4'd0);
                if (r_cnt == 4'd0) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                w_rsp_done = r_rsp_valid & bus.rsp_ready;
                if (r_rsp_valid && bus.rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // A clear arriving together with a use_acc request feeds the cleared value as operand A.
    assign w_acc_src = acc_clr ? ACC_INIT : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 4'd0;
            r_a         <= 8'h00;
            r_b         <= 8'h00;
            r_cmd       <= 4'h0;
            r_acc       <= ACC_INIT;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 16'h0000;
            r_rsp_zero  <= 1'b0;
            r_rsp_divz  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && acc_clr) begin
                r_acc <= ACC_INIT;
            end
            if (w_accept) begin
                r_a   <= bus.req_use_acc ? w_acc_src : bus.req_a;
                r_b   <= bus.req_b;
                r_cmd <= bus.req_op;
                r_cnt <= CNT_LOAD;
            end
            if (r_state == S_DRIVE && !w_last) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // alu_d is only looked at here, so a floating bus elsewhere never reaches state.
            if (w_last) begin
                r_rsp_data  <= alu_d;
                r_rsp_zero  <= (alu_d == 16'h0000);
                r_rsp_divz  <= (r_cmd == OP_DIV) && (r_b == 8'h00);
                r_acc       <= alu_d[7:0];
                r_rsp_valid <= 1'b1;
            end
            if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_zero  = r_rsp_zero;
    assign bus.rsp_divz  = r_rsp_divz;

    assign alu_a   = r_a;
    assign alu_b   = r_b;
    assign alu_cmd = r_cmd;
    assign alu_oe  = w_oe;
    assign acc     = r_acc;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Scoreboard bench: two drivers (settle 1 and settle 3) each on a behavioural tristate ALU.
module tb_alu_cmd_driver;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_INC = 4'b0011;
    localparam logic [3:0] OP_DIV = 4'b0101;
    localparam logic [3:0] OP_BUF = 4'b1111;

    typedef struct packed {
        logic [15:0] data;
        logic        zero;
        logic        divz;
        logic [7:0]  acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n0, rst_n1;
    logic dsel;
    logic t_valid, t_use_acc, t_clr, t_rr0, t_rr1;
    logic [3:0] t_op;
    logic [7:0] t_a, t_b;

    int n_checks = 0;
    int n_err    = 0;
    exp_t q0[$];
    exp_t q1[$];

    alu_cmd_driver_if if0 ();
    alu_cmd_driver_if if1 ();

    logic [7:0]  alu_a0, alu_b0, alu_a1, alu_b1, acc0, acc1;
    logic [3:0]  alu_cmd0, alu_cmd1;
    logic        alu_oe0, alu_oe1;
    wire  [15:0] alu_d0, alu_d1;

    function automatic logic [15:0] alu_f(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] r;
        case (c)
            OP_ADD:  r = 16'(a) + 16'(b);
            OP_SUB:  r = 16'(a) - 16'(b);
            OP_MUL:  r = 16'(a) * 16'(b);
            OP_INC:  r = 16'(a) + 16'd1;
            OP_DIV:  r = (b == 8'h00) ? 16'h0000 : 16'(a / b);
            OP_BUF:  r = 16'(a);
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    assign alu_d0 = alu_oe0 ? alu_f(alu_cmd0, alu_a0, alu_b0) : 16'bz;
    assign alu_d1 = alu_oe1 ? alu_f(alu_cmd1, alu_a1, alu_b1) : 16'bz;

    assign if0.req_valid   = t_valid & ~dsel;
    assign if0.req_op      = t_op;
    assign if0.req_a       = t_a;
    assign if0.req_b       = t_b;
    assign if0.req_use_acc = t_use_acc;
    assign if0.rsp_ready   = t_rr0;
    assign if1.req_valid   = t_valid & dsel;
    assign if1.req_op      = t_op;
    assign if1.req_a       = t_a;
    assign if1.req_b       = t_b;
    assign if1.req_use_acc = t_use_acc;
    assign if1.rsp_ready   = t_rr1;

    wire       clr0 = t_clr & ~dsel;
    wire       clr1 = t_clr & dsel;
    wire       m_ready = dsel ? if1.req_ready : if0.req_ready;
    wire       m_rsp_v = dsel ? if1.rsp_valid : if0.rsp_valid;
    wire       m_oe    = dsel ? alu_oe1 : alu_oe0;
    wire [7:0] m_a     = dsel ? alu_a1 : alu_a0;

    alu_cmd_driver #(.SETTLE_CYCLES(1), .ACC_INIT(8'h00)) dut0 (
        .clk(clk), .rst_n(rst_n0), .bus(if0.slave), .acc_clr(clr0),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_cmd(alu_cmd0), .alu_oe(alu_oe0),
        .alu_d(alu_d0), .acc(acc0)
    );

    alu_cmd_driver #(.SETTLE_CYCLES(3), .ACC_INIT(8'h00)) dut1 (
        .clk(clk), .rst_n(rst_n1), .bus(if1.slave), .acc_clr(clr1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_cmd(alu_cmd1), .alu_oe(alu_oe1),
        .alu_d(alu_d1), .acc(acc1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Monitors: pop and compare one expectation per completed response handshake.
    always @(negedge clk) begin
        if (if0.rsp_valid && if0.rsp_ready) begin
            if (q0.size() == 0) begin
                fail_now("dut0_unexpected_rsp");
            end else begin
                exp_t e;
                e = q0.pop_front();
                $display("rsp0 data=%h zero=%b divz=%b acc=%h", if0.rsp_data, if0.rsp_zero, if0.rsp_divz, acc0);
                chk("rsp0_data", 32'(if0.rsp_data), 32'(e.data));
                chk("rsp0_zero", 32'(if0.rsp_zero), 32'(e.zero));
                chk("rsp0_divz", 32'(if0.rsp_divz), 32'(e.divz));
                chk("rsp0_acc",  32'(acc0),         32'(e.acc));
            end
        end
    end

    always @(negedge clk) begin
        if (if1.rsp_valid && if1.rsp_ready) begin
            if (q1.size() == 0) begin
                fail_now("dut1_unexpected_rsp");
            end else begin
                exp_t e;
                e = q1.pop_front();
                $display("rsp1 data=%h zero=%b divz=%b acc=%h", if1.rsp_data, if1.rsp_zero, if1.rsp_divz, acc1);
                chk("rsp1_data", 32'(if1.rsp_data), 32'(e.data));
                chk("rsp1_zero", 32'(if1.rsp_zero), 32'(e.zero));
                chk("rsp1_divz", 32'(if1.rsp_divz), 32'(e.divz));
                chk("rsp1_acc",  32'(acc1),         32'(e.acc));
            end
        end
    end

    task automatic run_op(input logic sel, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic use_acc, input logic clr, input logic [15:0] e_data, input logic e_zero,
                          input logic e_divz, input logic [7:0] e_acc, input logic [7:0] e_a, input int settle);
        exp_t e;
        int   lat;
        int   oe_cnt;
        bit   ok;
        e = '{data: e_data, zero: e_zero, divz: e_divz, acc: e_acc};
        if (sel) q1.push_back(e); else q0.push_back(e);
        @(posedge clk); #1;
        dsel = sel; t_op = op; t_a = a; t_b = b; t_use_acc = use_acc; t_clr = clr; t_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            fail_now("accept");
            t_valid = 1'b0; t_clr = 1'b0;
            return;
        end
        @(posedge clk); #1;
        t_valid = 1'b0; t_clr = 1'b0;
        @(negedge clk);
        chk("alu_a", 32'(m_a), 32'(e_a));
        oe_cnt = m_oe ? 1 : 0;
        lat = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (m_rsp_v) begin ok = 1'b1; break; end
            if (m_oe) oe_cnt++;
        end
        if (!ok) begin
            fail_now("rsp_valid");
            return;
        end
        chk("latency",   32'(lat),     32'(settle));
        chk("oe_cycles", 32'(oe_cnt),  32'(settle));
        chk("oe_in_resp", 32'(m_oe),   32'd0);
        chk("ready_in_resp", 32'(m_ready), 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!m_rsp_v) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) fail_now("rsp_drain");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        logic [15:0] snap_d;
        logic        snap_z, snap_dz;
        bit          stable;
        bit          ok;

        rst_n0 = 1'b0; rst_n1 = 1'b0; dsel = 1'b0;
        t_valid = 1'b0; t_use_acc = 1'b0; t_clr = 1'b0; t_rr0 = 1'b1; t_rr1 = 1'b1;
        t_op = 4'h0; t_a = 8'h00; t_b = 8'h00;
        repeat (3) @(posedge clk);
        #1; rst_n0 = 1'b1; rst_n1 = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(if0.req_ready), 32'd1);
        chk("rst_oe",        32'(alu_oe0),       32'd0);
        chk("rst_rsp_valid", 32'(if0.rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(if0.rsp_data),  32'd0);
        chk("rst_acc",       32'(acc0),          32'd0);
        chk("rst_alu_a",     32'(alu_a0),        32'd0);

        run_op(1'b0, OP_ADD, 8'h12, 8'h34, 1'b0, 1'b0, 16'h0046, 1'b0, 1'b0, 8'h46, 8'h12, 1);
        run_op(1'b0, OP_MUL, 8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01, 1'b0, 1'b0, 8'h01, 8'hFF, 1);
        run_op(1'b0, OP_INC, 8'h99, 8'h00, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0, 8'h02, 8'h01, 1);
        run_op(1'b0, OP_ADD, 8'h77, 8'h05, 1'b1, 1'b1, 16'h0005, 1'b0, 1'b0, 8'h05, 8'h00, 1);
        run_op(1'b0, OP_DIV, 8'h40, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h00, 8'h40, 1);
        run_op(1'b0, OP_DIV, 8'h40, 8'h04, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 8'h10, 8'h40, 1);
        run_op(1'b0, OP_BUF, 8'h80, 8'h11, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b0, 8'h80, 8'h80, 1);

        // Backpressure with a second request waiting behind the held response.
        q0.push_back('{data: 16'h0003, zero: 1'b0, divz: 1'b0, acc: 8'h03});
        @(posedge clk); #1;
        t_rr0 = 1'b0; dsel = 1'b0; t_op = OP_ADD; t_a = 8'h01; t_b = 8'h02; t_use_acc = 1'b0; t_valid = 1'b1;
        @(posedge clk); #1;
        t_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if0.rsp_valid) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("bp_rsp_valid");
        snap_d = if0.rsp_data; snap_z = if0.rsp_zero; snap_dz = if0.rsp_divz;
        q0.push_back('{data: 16'h0007, zero: 1'b0, divz: 1'b0, acc: 8'h07});
        @(posedge clk); #1;
        t_op = OP_SUB; t_a = 8'h10; t_b = 8'h09; t_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (if0.rsp_data !== snap_d || if0.rsp_zero !== snap_z || if0.rsp_divz !== snap_dz ||
                if0.rsp_valid !== 1'b1 || if0.req_ready !== 1'b0 || alu_oe0 !== 1'b0)
                stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 32'd1);
        chk("bp_data", 32'(snap_d), 32'h0003);
        @(posedge clk); #1;
        t_rr0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_ready", 32'(if0.req_ready), 32'd1);
        chk("bp_not_early",  32'(alu_oe0),       32'd0);
        @(posedge clk); #1;
        t_valid = 1'b0;
        @(negedge clk);
        chk("bp_held_oe",    32'(alu_oe0), 32'd1);
        chk("bp_held_alu_a", 32'(alu_a0),  32'h10);
        for (int i = 0; i < 10; i++) @(negedge clk);

        // Three-cycle settle on the second driver.
        run_op(1'b1, OP_SUB, 8'h05, 8'h06, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 8'hFF, 8'h05, 3);

        // Reset in the middle of DRIVE: nothing must come back.
        @(posedge clk); #1;
        dsel = 1'b1; t_op = OP_ADD; t_a = 8'h01; t_b = 8'h01; t_use_acc = 1'b0; t_valid = 1'b1;
        @(negedge clk);
        chk("mid_ready", 32'(if1.req_ready), 32'd1);
        @(posedge clk); #1;
        t_valid = 1'b0;
        @(negedge clk);
        chk("mid_oe_before", 32'(alu_oe1), 32'd1);
        #2 rst_n1 = 1'b0;
        #1;
        chk("mid_oe_async", 32'(alu_oe1),       32'd0);
        chk("mid_acc",      32'(acc1),          32'h00);
        chk("mid_rsp_v",    32'(if1.rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n1 = 1'b1;
        @(negedge clk);
        chk("mid_ready_after", 32'(if1.req_ready), 32'd1);
        for (int i = 0; i < 6; i++) @(negedge clk);
        chk("mid_no_rsp", 32'(if1.rsp_valid), 32'd0);

        chk("q0_empty", 32'(q0.size()), 32'd0);
        chk("q1_empty", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
